cfg_frame_bank: RTL
===================

Name: cfg_frame_bank

Overview:
- Parametrised configuration-memory bank for one fabric column. It supersedes single-bit config latches with a framed, handshaked loader.
- Accepts configuration words over a valid/ready stream and assembles them into a frame-wide shadow register.
- Commits each completed frame to one of FRAMES addressed storage rows. Each row drives true and complement configuration bits into the column's switch-matrix muxes and LUTs.

Parameters:
- FRAME_BITS, 32: bits per frame; must be a multiple of WORD_W.
- FRAMES, 20: number of frame rows.
- WORD_W, 8: configuration word width per handshake.
- ADDR_W, $clog2(FRAMES) (min 1): frame address width.

Ports:
- CLK  in  1  single clock.
- resetn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  word valid.
- cfg_ready  out  1  bank can accept a word.
- cfg_data  in  WORD_W  configuration word.
- cfg_addr  in  ADDR_W  target frame; sampled on the first word of each frame.
- cfg_abort  in  1  discard the frame in progress.
- err_clr  in  1  clear sticky error.
- frame_done  out  1  one-cycle pulse when a frame commits.
- err  out  1  sticky: a frame was addressed at or beyond FRAMES.
- busy  out  1  high while in LOAD or COMMIT.
- conf_bits  out  FRAMES*FRAME_BITS  frame f occupies [f*FRAME_BITS +: FRAME_BITS].
- conf_bits_n  out  FRAMES*FRAME_BITS  bitwise complement of conf_bits.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; shadow, word counter and latched address = 0.
  - conf_bits all 0; conf_bits_n all 1.
  - frame_done=0, err=0, busy=0, cfg_ready=0 while resetn=0.
  - cfg_ready rises on the first clock edge after release.
- Handshake: a word transfers on a rising CLK edge with cfg_valid & cfg_ready. cfg_ready depends only on state; it does not depend combinationally on cfg_valid.
- States:
  - IDLE: cfg_ready=1. On transfer: latch cfg_addr, shadow <= {shadow[FRAME_BITS-WORD_W-1:0], cfg_data}, counter=1.
    - If FRAME_BITS==WORD_W, go to COMMIT.
    - Otherwise go to LOAD.
  - LOAD: cfg_ready=1. Each transfer shifts shadow left by WORD_W and increments the counter. On transfer number FRAME_BITS/WORD_W, go to COMMIT.
  - COMMIT: one cycle, cfg_ready=0.
    - If latched addr < FRAMES: row[addr] <= shadow and frame_done=1 next cycle.
    - Otherwise: no row write, frame_done=0, err set.
    - Return to IDLE; counter cleared.
- Bit order: the first word of a frame lands in bits [FRAME_BITS-1 -: WORD_W], MSB-first.
- Latency: frame_done is asserted in the cycle after COMMIT. The rows update on the same edge that raises frame_done, i.e. two edges after the last word transfer.
- cfg_addr is ignored except on the first word of a frame.
- cfg_abort:
  - In LOAD or IDLE: go to IDLE next edge; shadow and counter cleared; no commit.
  - Abort has priority over a simultaneous transfer.
  - Ignored in COMMIT; the commit completes.
- err/err_clr:
  - err_clr clears err next edge.
  - If an err set and err_clr occur in the same cycle, set wins.
- Rows not addressed hold their value indefinitely. Rewriting a row overwrites all its bits.
- conf_bits and conf_bits_n change only on a commit edge or on reset. They are never glitched by the shadow.
- If resetn is asserted mid-frame, all state and rows return to reset values. No partial frame is committed.

Optional Feature:
- Macro: CFG_FRAME_READBACK_EN.
- With the macro defined, ports are added:
  - rb_req in 1
  - rb_addr in ADDR_W
  - rb_valid out 1
  - rb_data out WORD_W
- Readback behaviour:
  - rb_req sampled in IDLE only; it has priority over a simultaneous cfg transfer, and cfg_ready=0 that cycle.
  - State RB: shadow <= row[rb_addr], or 0 if rb_addr >= FRAMES (err set).
  - Then FRAME_BITS/WORD_W consecutive cycles with rb_valid=1 and rb_data = shadow MSB word, shifting left each cycle. No backpressure.
  - Then IDLE. cfg_ready=0 and busy=1 throughout RB.
  - cfg_abort terminates RB next edge.
- Without the macro: no readback ports, no RB state; behaviour is as above.

Test Plan:
- Reset: hold resetn=0 with CLK running → conf_bits==0, conf_bits_n all 1, cfg_ready=0; after release cfg_ready=1 next edge, err=0.
- Frame write (FRAME_BITS=32, WORD_W=8): cfg_addr=3, words 0xDE,0xAD,0xBE,0xEF back-to-back → frame_done pulses exactly once, two edges after the 0xEF transfer. conf_bits[127:96]==0xDEADBEEF, conf_bits_n[127:96]==0x21524110, other frames 0.
- Gapped valid + address change: frame 0 words 0x01,0x23,0x45,0x67 with cfg_valid low for 3 cycles between words, cfg_addr toggled after the first word → frame 0 ==0x01234567, frame 1 unchanged.
- Abort: send 0xAA,0xBB to frame 5, assert cfg_abort with a third word valid → no frame_done, frame 5 unchanged. A following full frame 0x11223344 to frame 5 commits correctly.
- Bad address: cfg_addr=20 (FRAMES=20), four words → err=1, no frame_done, all rows unchanged. err_clr and a new error in the same cycle → err stays 1; err_clr alone → 0.
- Readback (CFG_FRAME_READBACK_EN): after writing 0xDEADBEEF to frame 3, rb_req with rb_addr=3 → rb_valid high for exactly 4 cycles, rb_data 0xDE,0xAD,0xBE,0xEF; cfg_ready=0 throughout.

Source files
------------

// File: rtl/cfg_frame_bank.sv
// cfg_frame_bank - configuration-memory bank for one fabric column.
//
// Configuration words arrive over a valid/ready stream. They are shifted
// MSB-first into a frame-wide shadow register. Each completed frame is
// committed to one of FRAMES storage rows. The rows drive true and
// complement configuration bits into the column.
//
// Ports:
//   CLK, resetn      clock, asynchronous active-low reset
//   cfg_valid/ready  word handshake; cfg_data carries the word
//   cfg_addr         target row, sampled on the first word of a frame
//   cfg_abort        drop the frame in progress (ignored during COMMIT)
//   err_clr          clear the sticky err flag
//   frame_done       one-cycle pulse when a row is written
//   err              sticky flag: a frame or readback addressed a row >= FRAMES
//   busy             high in LOAD / COMMIT (and RB)
//   conf_bits(_n)    row f occupies [f*FRAME_BITS +: FRAME_BITS]; _n is its complement
//
// Optional readback, enabled by defining CFG_FRAME_READBACK_EN:
//   rb_req/rb_addr   request a row dump (accepted in IDLE only)
//   rb_valid/rb_data the row streamed out MSB word first, one word per cycle
module cfg_frame_bank #(
  parameter int FRAME_BITS = 32,
  parameter int FRAMES     = 20,
  parameter int WORD_W     = 8,
  parameter int ADDR_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [WORD_W-1:0]            cfg_data,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic                         cfg_abort,
  input  logic                         err_clr,
  output logic                         frame_done,
  output logic                         err,
  output logic                         busy,
  output logic [FRAMES*FRAME_BITS-1:0] conf_bits,
  output logic [FRAMES*FRAME_BITS-1:0] conf_bits_n
`ifdef CFG_FRAME_READBACK_EN
  ,
  input  logic                         rb_req,
  input  logic [ADDR_W-1:0]            rb_addr,
  output logic                         rb_valid,
  output logic [WORD_W-1:0]            rb_data
`endif
);

  localparam int WPF   = FRAME_BITS / WORD_W;
  localparam int CNT_W = $clog2(WPF + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WPF - 1);
  localparam logic [ADDR_W:0]   FRAMES_C = (ADDR_W + 1)'(FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_RB} state_t;

  state_t                              r_state, w_next;
  logic [FRAME_BITS-1:0]               r_shadow;
  logic [CNT_W-1:0]                    r_cnt;
  logic [ADDR_W-1:0]                   r_addr;
  logic [FRAMES-1:0][FRAME_BITS-1:0]   r_rows;
  logic                                r_done;
  logic                                r_err;
  // Holds cfg_ready low until the first edge after reset release.
  logic                                r_rdy_en;

  logic                                w_xfer;
  logic                                w_abort;
  logic                                w_addr_ok;
  logic                                w_commit_ok;
  logic                                w_err_set;
  logic                                w_rb_start;
  logic [FRAME_BITS+WORD_W-1:0]        w_cat;
  logic [FRAME_BITS-1:0]               w_shift_in;

  // Concatenate then truncate so the shift is legal even when FRAME_BITS == WORD_W.
  assign w_cat      = {r_shadow, cfg_data};
  assign w_shift_in = w_cat[FRAME_BITS-1:0];

  assign w_xfer      = cfg_valid & cfg_ready;
  assign w_abort     = cfg_abort & (r_state != S_COMMIT);
  assign w_addr_ok   = ({1'b0, r_addr} < FRAMES_C);
  assign w_commit_ok = (r_state == S_COMMIT) & w_addr_ok;

`ifdef CFG_FRAME_READBACK_EN
  logic                  w_rb_addr_ok;
  logic [FRAME_BITS-1:0] w_rb_row;

  assign w_rb_start   = (r_state == S_IDLE) & r_rdy_en & rb_req & ~cfg_abort;
  assign w_rb_addr_ok = ({1'b0, rb_addr} < FRAMES_C);
  assign w_rb_row     = w_rb_addr_ok ? r_rows[rb_addr] : '0;
  assign rb_data      = r_shadow[FRAME_BITS-1 -: WORD_W];
`else
  assign w_rb_start   = 1'b0;
`endif

  assign w_err_set = ((r_state == S_COMMIT) & ~w_addr_ok)
`ifdef CFG_FRAME_READBACK_EN
                   | (w_rb_start & ~w_rb_addr_ok)
`endif
                   ;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_abort)         w_next = S_IDLE;
        else if (w_rb_start) w_next = S_RB;
        else if (w_xfer)     w_next = (WPF == 1) ? S_COMMIT : S_LOAD;
      end
      S_LOAD: begin
        if (w_abort)                            w_next = S_IDLE;
        else if (w_xfer && r_cnt == LAST_CNT)   w_next = S_COMMIT;
      end
      S_COMMIT: w_next = S_IDLE;
      S_RB: begin
        if (w_abort || r_cnt == LAST_CNT) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
`ifdef CFG_FRAME_READBACK_EN
    rb_valid  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef CFG_FRAME_READBACK_EN
        cfg_ready = r_rdy_en & ~rb_req;
`else
        cfg_ready = r_rdy_en;
`endif
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
      end
      S_COMMIT: busy = 1'b1;
      S_RB: begin
        busy = 1'b1;
`ifdef CFG_FRAME_READBACK_EN
        rb_valid = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // ---------------- Shadow, word counter, latched address ----------------
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_abort) begin
            r_shadow <= '0;
            r_cnt    <= '0;
          end else if (w_rb_start) begin
`ifdef CFG_FRAME_READBACK_EN
            r_shadow <= w_rb_row;
`endif
            r_cnt    <= '0;
          end else if (w_xfer) begin
            r_shadow <= w_shift_in;
            r_cnt    <= CNT_W'(1);
            r_addr   <= cfg_addr;
          end
        end
        S_LOAD: begin
          if (w_abort) begin
            r_shadow <= '0;
            r_cnt    <= '0;
          end else if (w_xfer) begin
            r_shadow <= w_shift_in;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end
        S_COMMIT: r_cnt <= '0;
        S_RB: begin
          // Each cycle presents the MSB word, then shifts the next one up.
          if (w_abort) begin
            r_shadow <= '0;
            r_cnt    <= '0;
          end else begin
            r_shadow <= w_cat[FRAME_BITS-1:0] & {{(FRAME_BITS-WORD_W){1'b1}}, {WORD_W{1'b0}}};
            r_cnt    <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- Storage rows and status ----------------
  // Rows only change on a commit edge, so the column never sees shadow activity.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_rows   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_done   <= w_commit_ok;
      if (w_commit_ok) r_rows[r_addr] <= r_shadow;
      // A new error outranks a simultaneous clear.
      if (w_err_set)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign frame_done  = r_done;
  assign err         = r_err;
  assign conf_bits   = r_rows;
  assign conf_bits_n = ~r_rows;

endmodule
